// File: rtl/regfile_sb_if.sv
// Register-file access bundle: two read ports, one byte-enabled write
// port and the issue/scoreboard signals shared with pipeline control.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]   reg1addr;
  logic [ADDR_WIDTH-1:0]   reg2addr;
  logic [DATA_WIDTH-1:0]   reg1content;
  logic [DATA_WIDTH-1:0]   reg2content;
  logic                    reg1busy;
  logic                    reg2busy;
  logic                    regWrite;
  logic [ADDR_WIDTH-1:0]   regWaddr;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] byteEn;
  logic                    issue;
  logic [ADDR_WIDTH-1:0]   issueAddr;
  logic [ADDR_WIDTH:0]     busyCount;

  modport master (
    output reg1addr, reg2addr,
    output regWrite, regWaddr, data, byteEn,
    output issue, issueAddr,
    input  reg1content, reg2content,
    input  reg1busy, reg2busy, busyCount
  );

  modport slave (
    input  reg1addr, reg2addr,
    input  regWrite, regWaddr, data, byteEn,
    input  issue, issueAddr,
    output reg1content, reg2content,
    output reg1busy, reg2busy, busyCount
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two bypassed read ports, a byte-enabled write port
// and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] wmask;
  logic                  wr_ok;
  logic                  iss_ok;
  logic                  hit1;
  logic                  hit2;
  logic                  inc;
  logic                  dec;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] nw,
    input logic [DATA_WIDTH-1:0] m
  );
    return (old & ~m) | (nw & m);
  endfunction

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++)
      wmask[8*i +: 8] = {8{bus.byteEn[i]}};
  end

  assign wr_ok  = bus.regWrite &&
                  (!ZERO_REG || bus.regWaddr != '0);
  assign iss_ok = bus.issue &&
                  (!ZERO_REG || bus.issueAddr != '0);

  assign hit1 = wr_ok && bus.regWaddr == bus.reg1addr;
  assign hit2 = wr_ok && bus.regWaddr == bus.reg2addr;

  always_comb begin
    bus.reg1content = regs[bus.reg1addr];
    if (hit1)
      bus.reg1content = merge(regs[bus.reg1addr],
                              bus.data, wmask);
    if (ZERO_REG && bus.reg1addr == '0)
      bus.reg1content = '0;
  end

  always_comb begin
    bus.reg2content = regs[bus.reg2addr];
    if (hit2)
      bus.reg2content = merge(regs[bus.reg2addr],
                              bus.data, wmask);
    if (ZERO_REG && bus.reg2addr == '0)
      bus.reg2content = '0;
  end

  // A completing write is bypassed, so it no longer counts as a hazard
  assign bus.reg1busy = busy[bus.reg1addr] && !hit1;
  assign bus.reg2busy = busy[bus.reg2addr] && !hit2;

  assign inc = iss_ok && !busy[bus.issueAddr];
  assign dec = wr_ok && busy[bus.regWaddr] &&
               !(iss_ok && bus.issueAddr == bus.regWaddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        for (int i = 0; i < NB; i++)
          if (bus.byteEn[i])
            regs[bus.regWaddr][8*i +: 8] <= bus.data[8*i +: 8];
        busy[bus.regWaddr] <= 1'b0;
      end
      // Issued later so a same-address new producer wins
      if (iss_ok)
        busy[bus.issueAddr] <= 1'b1;
      unique case ({inc, dec})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.busyCount = count;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the MIPS processor's 32x32 register file. Provides two combinational read ports and one byte-enabled write port with same-cycle write-to-read bypass. Register 0 is hardwired to zero, and all registers clear on a synchronous reset. A per-register pending-write scoreboard lets the pipeline control unit detect RAW hazards on in-flight destinations.

Parameters:
DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH.
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending; 0 = register 0 is ordinary.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
reg1addr  in  ADDR_WIDTH  read port 1 address.
reg2addr  in  ADDR_WIDTH  read port 2 address.
reg1content  out  DATA_WIDTH  read port 1 data (combinational).
reg2content  out  DATA_WIDTH  read port 2 data (combinational).
reg1busy  out  1  read port 1 register has a pending write.
reg2busy  out  1  read port 2 register has a pending write.
regWrite  in  1  write enable.
regWaddr  in  ADDR_WIDTH  write address.
data  in  DATA_WIDTH  write data.
byteEn  in  DATA_WIDTH/8  per-byte write enable; lane i covers bits 8i+7:8i.
issue  in  1  mark a destination as pending (instruction issued).
issueAddr  in  ADDR_WIDTH  destination register being issued.
busyCount  out  ADDR_WIDTH+1  number of registers currently pending (registered).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1, all registers go to 0, all busy bits to 0, and busyCount to 0. rst overrides regWrite and issue in the same cycle. After reset, both read ports return 0 and both busy outputs are 0.
- Write: on the rising edge, when regWrite=1 and the target is writable, each lane with byteEn[i]=1 takes data[lane]. Lanes with byteEn[i]=0 keep their old value. byteEn=0 with regWrite=1 changes no data but still clears busy.
- Writable target: regWaddr != 0, or ZERO_REG=0.
- Read: reg1content = array[reg1addr], with bypass.
  - Bypass applies when regWrite=1, regWaddr==reg1addr and the target is writable. The enabled lanes then come from data and the rest from the array.
  - Read latency is 0 cycles; the written value is also visible from the array the next cycle.
  - Port 2 behaves the same way.
- Zero register: with ZERO_REG=1, address 0 always reads 0, ignores writes, and issue to address 0 is ignored.
- Scoreboard update on the rising edge (rst=0):
  - issue=1 to a writable issueAddr sets busy[issueAddr].
  - regWrite=1 to a writable regWaddr clears busy[regWaddr].
  - Same address in the same cycle: set wins, since the new producer supersedes the completing one.
  - Issue to an already-busy register keeps it busy; busyCount is unchanged.
  - A write to a non-busy register keeps it clear.
- Busy outputs (combinational):
  - reg1busy = busy[reg1addr] AND NOT (regWrite AND regWaddr==reg1addr AND writable).
  - The completing write is bypassed, so it is not reported as a hazard.
  - A same-cycle issue does not affect reg1busy until the next cycle.
  - Port 2 behaves the same way.
- busyCount: registered; equals the population count of busy after every edge. It changes by -1, 0 or +1 per cycle and never overflows, because the maximum is DEPTH, which fits in ADDR_WIDTH+1 bits.
- Same address on both read ports: both return identical data and busy.

Test Plan:
- Reset: with rst=1 for one edge after registers are written, all reads return 0x00000000, busy outputs are 0, and busyCount=0.
- Bypass: write 0xDEADBEEF to reg 8 with byteEn=4'hF while reg1addr=8. reg1content=0xDEADBEEF in the same cycle, and it still reads 0xDEADBEEF the next cycle.
- Byte enable: with reg 9=0x11223344, write 0xAABBCCDD with byteEn=4'b0101. Reg 9 becomes 0x11BB33DD.
- Zero register: write 0xFFFFFFFF to reg 0 and issue reg 0. Reg 0 reads 0, reg1busy=0, busyCount=0. With ZERO_REG=0, reg 0 reads 0xFFFFFFFF.
- Scoreboard:
  - Issue 16, then issue 17: busyCount goes 1, 2 and reg1busy(16)=1.
  - Write 16: reg1busy(16)=0 in the write cycle and busyCount=1 afterwards.
  - Issue and write 17 in the same cycle: 17 stays busy and busyCount=1.
- Reset mid-operation: assert rst in the same cycle as issue 18 and write 19=5. After the edge, reg 19=0, 18 is not busy, and busyCount=0.
